truth_table_checker: RTL and testbench
======================================

// Module: truth_table_checker
// PURPOSE
//  Response-side counterpart of the 3-input stimulus sweep used for Circuit-style
//  logic blocks. It accepts {a,b,c,o} observations over a valid/ready handshake and
//  compares each o against a golden 8-entry truth table. It records which input
//  combinations have been seen and counts mismatches. It reports pass/fail once all
//  8 combinations are covered, or when a timeout expires.
//  It sits between the device under test and the bench/status logic.
// PARAMETERS
//  GOLDEN   8'h1A  expected o per index {a,b,c}; bit i = expected o for i
//                  (8'h1A = ((!a|b)&c)^(a&(!b^c)))
//  CNT_W    4      width of err_count; saturates at all-ones
//  TIMEOUT  16     idle cycles in COLLECT before forced report; 0 = disabled
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous reset, active high
//  start          in   1      begin a new check run (IDLE/REPORT only)
//  in_valid       in   1      observation present
//  in_ready       out  1      checker accepts observation this cycle
//  in_a,in_b,in_c in   1 each input vector applied to the DUT; idx = {in_a,in_b,in_c}
//  in_o           in   1      DUT output for that vector
//  busy           out  1      high in COLLECT
//  done           out  1      high in REPORT
//  pass           out  1      done & all 8 seen & err_count==0
//  timed_out      out  1      run ended by TIMEOUT
//  seen_mask      out  8      bit i set once idx i has been accepted
//  obs_table      out  8      bit i = last accepted in_o for idx i
//  err_count      out  CNT_W  number of mismatching accepts, saturating
//  first_err_idx  out  3      idx of first mismatch in the run
//  first_err_vld  out  1      first_err_idx is valid
// BEHAVIOUR
//  - rst (any state, including mid-run): state=IDLE; every output 0; idle counter 0.
//  - FSM: IDLE -start-> COLLECT; COLLECT -mask full or timeout-> REPORT;
//    REPORT -start-> COLLECT. start is ignored in COLLECT.
//  - Entering COLLECT clears seen_mask, obs_table, err_count, first_err_*,
//    timed_out and the idle counter.
//  - in_ready = (state==COLLECT). Accept = in_valid & in_ready, registered at that edge.
//  - On accept: set seen_mask[idx]; write obs_table[idx]=in_o.
//    If in_o != GOLDEN[idx], increment err_count (hold at 2^CNT_W-1), and if
//    !first_err_vld, capture idx and set first_err_vld.
//  - Duplicate idx: compared and counted again; obs_table keeps the latest value.
//  - The accepting edge that makes seen_mask==8'hFF also moves the state to REPORT.
//    done is high from the next cycle; in_ready is low from then on.
//  - Idle counter: +1 per COLLECT cycle with no accept; cleared on accept.
//    On the edge where it reaches TIMEOUT-1 with no accept, go to REPORT and set
//    timed_out=1.
//  - An accept in the same cycle as timeout expiry takes priority: it is recorded
//    and the timeout does not fire.
//  - pass is combinational from the registered state:
//    done & seen_mask==8'hFF & err_count==0. It is therefore 0 whenever timed_out=1.
//  - REPORT holds all results stable until start or rst.
// TESTING
//  1 start, then 8 accepts of idx 0..7 with o=GOLDEN[idx]
//    -> done=1 on the cycle after the 8th accept; pass=1; seen_mask=FF;
//       obs_table=1A; err_count=0.
//  2 Same sweep but idx 5 sends o=1 and idx 7 sends o=1
//    -> err_count=2; first_err_idx=5; first_err_vld=1; obs_table=BA; pass=0.
//  3 idx 3 sent twice (o=1, then o=0), then the rest correct
//    -> err_count=1; obs_table bit3=0; done only after all 8 are seen.
//  4 Accept idx 0..5, then in_valid=0 for 16 cycles
//    -> REPORT; timed_out=1; seen_mask=3F; pass=0; in_ready=0.
//  5 rst asserted after 4 accepts
//    -> next cycle: state IDLE, all outputs 0; start then a full sweep passes.
//  6 start during COLLECT, and in_valid held high in REPORT
//    -> both ignored: no clear, no accept; err_count=15 saturation holds
//       under 20 forced mismatches with CNT_W=4.

Source files
------------

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - checks {a,b,c,o} observations against an 8-entry golden truth table
module truth_table_checker #(
    parameter logic [7:0] GOLDEN  = 8'h1A,
    parameter int         CNT_W   = 4,
    parameter int         TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_c,
    input  logic             in_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timed_out,
    output logic [7:0]       seen_mask,
    output logic [7:0]       obs_table,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       first_err_idx,
    output logic             first_err_vld
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_REPORT
    } state_t;

    // The idle counter only has to count up to TIMEOUT-2: the cycle that would
    // take it to TIMEOUT-1 is the one that fires the timeout.
    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_FIRE = (TIMEOUT >= 2) ? IDLE_W'(TIMEOUT - 2) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;

    logic [2:0] idx;
    logic       accept;
    logic       mismatch;
    logic       start_run;
    logic [7:0] seen_next;

    assign idx       = {in_a, in_b, in_c};
    assign in_ready  = (state == S_COLLECT);
    assign busy      = (state == S_COLLECT);
    assign done      = (state == S_REPORT);
    assign accept    = in_valid & in_ready;
    assign mismatch  = (in_o != GOLDEN[idx]);
    assign start_run = start & (state != S_COLLECT);
    assign seen_next = seen_mask | (8'b1 << idx);
    assign pass      = done & (seen_mask == 8'hFF) & (err_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            idle_cnt      <= '0;
            timed_out     <= 1'b0;
            seen_mask     <= '0;
            obs_table     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (start_run) begin
            state         <= S_COLLECT;
            idle_cnt      <= '0;
            timed_out     <= 1'b0;
            seen_mask     <= '0;
            obs_table     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (state == S_COLLECT) begin
            if (accept) begin
                idle_cnt       <= '0;
                seen_mask      <= seen_next;
                obs_table[idx] <= in_o;
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!first_err_vld) begin
                        first_err_idx <= idx;
                        first_err_vld <= 1'b1;
                    end
                end
                if (seen_next == 8'hFF) begin
                    state <= S_REPORT;
                end
            end else if (TIMEOUT_EN && (idle_cnt == IDLE_FIRE)) begin
                state     <= S_REPORT;
                timed_out <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - scoreboard bench for truth_table_checker with a behavioural model
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_a = 1'b0, in_b = 1'b0, in_c = 1'b0, in_o = 1'b0;
    logic       busy, done, pass, timed_out;
    logic [7:0] seen_mask, obs_table;
    logic [3:0] err_count;
    logic [2:0] first_err_idx;
    logic       first_err_vld;

    truth_table_checker #(.GOLDEN(8'h1A), .CNT_W(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_o(in_o),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .seen_mask(seen_mask), .obs_table(obs_table), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       to;
        bit [7:0] seen;
        bit [7:0] obs;
        int       err;
        bit [2:0] fidx;
        bit       fvld;
        bit       pass;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   q_idx[$];
    bit   q_o[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit golden_o(input int idx);
        bit a, b, c;
        a = idx[2];
        b = idx[1];
        c = idx[0];
        return ((!a | b) & c) ^ (a & (!b ^ c));
    endfunction

    // Replays the queued observations; anything after full coverage is never accepted.
    function automatic exp_t model();
        exp_t e;
        e.seen = 0; e.obs = 0; e.err = 0; e.fidx = 0; e.fvld = 0;
        foreach (q_idx[i]) begin
            if (e.seen == 8'hFF) break;
            e.seen[q_idx[i]] = 1'b1;
            e.obs[q_idx[i]]  = q_o[i];
            if (q_o[i] != golden_o(q_idx[i])) begin
                e.err = (e.err < 15) ? e.err + 1 : 15;
                if (!e.fvld) begin
                    e.fidx = 3'(q_idx[i]);
                    e.fvld = 1'b1;
                end
            end
        end
        e.to   = (e.seen != 8'hFF);
        e.pass = (e.seen == 8'hFF) && (e.err == 0);
        return e;
    endfunction

    task automatic push_expected();
        last_exp = model();
        exp_q.push_back(last_exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_seq(input int lo, input int hi, input int gapmax);
        for (int i = lo; i <= hi; i++) begin
            if (gapmax > 0) idle($urandom_range(0, gapmax));
            @(negedge clk);
            if (!in_ready) begin
                in_valid = 1'b0;
                break;
            end
            in_valid = 1'b1;
            {in_a, in_b, in_c} = 3'(q_idx[i]);
            in_o = q_o[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done", done, 1);
    endtask

    task automatic sweep_q(input int bad_mask);
        q_idx.delete();
        q_o.delete();
        for (int i = 0; i < 8; i++) begin
            q_idx.push_back(i);
            q_o.push_back(golden_o(i) ^ bad_mask[i]);
        end
    endtask

    // Monitor: compares a full report whenever done rises.
    initial begin
        logic done_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_report", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("timed_out", timed_out, e.to);
                    chk("seen_mask", seen_mask, e.seen);
                    chk("obs_table", obs_table, e.obs);
                    chk("err_count", err_count, e.err);
                    chk("first_err_vld", first_err_vld, e.fvld);
                    if (e.fvld) chk("first_err_idx", first_err_idx, e.fidx);
                    chk("pass", pass, e.pass);
                    chk("in_ready_report", in_ready, 0);
                end
            end
            done_q = done;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, {busy, done, pass, timed_out, in_ready, first_err_vld}, 0);
        chk({tag, "_seen"}, seen_mask, 0);
        chk({tag, "_obs"}, obs_table, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_fidx"}, first_err_idx, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // 1: clean sweep, done exactly one cycle after the 8th accept
        sweep_q(0);
        push_expected();
        do_start();
        chk("busy_after_start", busy, 1);
        run_seq(0, 7, 0);
        chk("t1_done_latency", done, 1);
        chk("t1_pass", pass, 1);

        // 2: idx 5 and 7 wrong
        sweep_q(8'hA0);
        push_expected();
        do_start();
        run_seq(0, 7, 0);
        wait_done(4);
        chk("t2_obs", obs_table, 8'hBA);

        // 3: duplicate idx 3, report only after full coverage
        q_idx = '{3, 3, 0, 1, 2, 4, 5, 6, 7};
        q_o   = '{1, 0, 0, 1, 0, 1, 0, 0, 0};
        push_expected();
        do_start();
        run_seq(0, 7, 0);
        chk("t3_not_done_at_7_distinct", busy, 1);
        run_seq(8, 8, 0);
        chk("t3_done", done, 1);
        chk("t3_obs_bit3", obs_table[3], 0);

        // 4: timeout after 0..5
        sweep_q(0);
        q_idx = q_idx[0:5];
        q_o   = q_o[0:5];
        push_expected();
        do_start();
        run_seq(0, 5, 0);
        repeat (14) @(negedge clk);
        chk("t4_busy_before_timeout", busy, 1);
        repeat (3) @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_timed_out", timed_out, 1);
        chk("t4_ready", in_ready, 0);

        // 5: reset mid-run, then a clean sweep
        sweep_q(0);
        do_start();
        run_seq(0, 3, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("t5_rst");
        push_expected();
        do_start();
        run_seq(0, 7, 1);
        wait_done(4);
        chk("t5_pass", pass, 1);

        // 6: saturation, start ignored in COLLECT, valid ignored in REPORT
        q_idx.delete();
        q_o.delete();
        for (int i = 0; i < 20; i++) begin
            q_idx.push_back(0);
            q_o.push_back(1);
        end
        for (int i = 1; i < 8; i++) begin
            q_idx.push_back(i);
            q_o.push_back(golden_o(i));
        end
        push_expected();
        do_start();
        run_seq(0, 19, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy_after_start", busy, 1);
        chk("t6_err_sat", err_count, 15);
        chk("t6_seen_kept", seen_mask, 8'h01);
        run_seq(20, 26, 0);
        wait_done(4);
        in_valid = 1'b1;
        {in_a, in_b, in_c} = 3'd2;
        in_o = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("t6_hold_done", done, 1);
        chk("t6_hold_err", err_count, last_exp.err);
        chk("t6_hold_obs", obs_table, last_exp.obs);
        chk("t6_hold_seen", seen_mask, 8'hFF);

        // randomized runs with bubbles and occasional wrong outputs
        for (int r = 0; r < 6; r++) begin
            bit [7:0] cov = 0;
            q_idx.delete();
            q_o.delete();
            while (cov != 8'hFF && q_idx.size() < 60) begin
                int ix = $urandom_range(0, 7);
                q_idx.push_back(ix);
                q_o.push_back(golden_o(ix) ^ ($urandom_range(0, 7) == 0));
                cov[ix] = 1'b1;
            end
            push_expected();
            do_start();
            run_seq(0, q_idx.size() - 1, 3);
            wait_done(40);
        end

        idle(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
